// File: rtl/fetch_unit.sv
// 6502 instruction fetch front end: reads the reset vector, then assembles
// opcode + operand bytes into a bundle handed to decode with valid/ready.
module fetch_unit #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic [1:0]  len_in,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_op1,
  output logic [7:0]  inst_op2,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc_out
);

  typedef enum logic [2:0] {VEC_LO, VEC_HI, OPC, OP1, OP2, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;

  logic [1:0]  eff_len;
  logic        xfer;
  logic        redirect_active;

  // A decoder length of 0 is treated as a single-byte instruction.
  assign eff_len = (len_in == 2'd0) ? 2'd1 : len_in;
  assign xfer    = mem_rd && mem_ready;
  assign redirect_active = redirect_valid && (state_q != VEC_LO) && (state_q != VEC_HI);

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      VEC_LO: begin mem_addr = RESET_VEC;         mem_rd = 1'b1; end
      VEC_HI: begin mem_addr = RESET_VEC + 16'd1; mem_rd = 1'b1; end
      OPC:    mem_rd = 1'b1;
      OP1:    mem_rd = (eff_len != 2'd1);
      OP2:    mem_rd = 1'b1;
      default: mem_rd = 1'b0;
    endcase
    if (rst) mem_rd = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    len_d    = len_q;
    ipc_d    = ipc_q;
    // Redirect wins over any byte arriving this cycle; that byte is dropped.
    if (redirect_active) begin
      pc_d    = redirect_pc;
      state_d = OPC;
    end else begin
      case (state_q)
        VEC_LO: if (xfer) begin
          pc_d[7:0] = mem_rdata;
          state_d   = VEC_HI;
        end
        VEC_HI: if (xfer) begin
          pc_d[15:8] = mem_rdata;
          state_d    = OPC;
        end
        OPC: if (xfer) begin
          opcode_d = mem_rdata;
          ipc_d    = pc_q;
          pc_d     = pc_q + 16'd1;
          op1_d    = 8'h00;
          op2_d    = 8'h00;
          state_d  = OP1;
        end
        OP1: begin
          if (eff_len == 2'd1) begin
            len_d   = 2'd1;
            state_d = HOLD;
          end else if (xfer) begin
            op1_d   = mem_rdata;
            pc_d    = pc_q + 16'd1;
            len_d   = eff_len;
            state_d = (eff_len == 2'd3) ? OP2 : HOLD;
          end
        end
        OP2: if (xfer) begin
          op2_d   = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = HOLD;
        end
        HOLD: if (inst_ready) state_d = OPC;
        default: state_d = VEC_LO;
      endcase
    end
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= VEC_LO;
      pc_q     <= 16'h0000;
      opcode_q <= 8'h00;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      len_q    <= 2'd1;
      ipc_q    <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      len_q    <= len_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
    end
  end

  assign inst_opcode = opcode_q;
  assign inst_op1    = op1_q;
  assign inst_op2    = op2_q;
  assign inst_len    = len_q;
  assign inst_pc     = ipc_q;
  assign inst_valid  = valid_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a byte memory and a
// bundle-level reference model (next pc = pc + instruction length).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [1:0]  len_in;
  logic [7:0]  inst_opcode, inst_op1, inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] pc_out;

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_VEC(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .len_in(len_in),
    .inst_opcode(inst_opcode), .inst_op1(inst_op1), .inst_op2(inst_op2),
    .inst_len(inst_len), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_out(pc_out)
  );

  // Stand-in for the prime decoder: a few fixed opcodes, otherwise low two bits.
  function automatic logic [1:0] len_of(input logic [7:0] op);
    if (op == 8'hEA) return 2'd1;
    if (op == 8'h4C) return 2'd3;
    return op[1:0];
  endfunction

  assign mem_rdata = mem[mem_addr];
  assign len_in    = len_of(inst_opcode);

  function automatic logic [47:0] exp_bundle(input logic [15:0] pc);
    logic [7:0]  op, o1, o2;
    logic [1:0]  l;
    logic [15:0] a1, a2;
    op = mem[pc];
    l  = (len_of(op) == 2'd0) ? 2'd1 : len_of(op);
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    o1 = (l >= 2'd2) ? mem[a1] : 8'h00;
    o2 = (l == 2'd3) ? mem[a2] : 8'h00;
    return {op, o1, o2, 6'd0, l, pc};
  endfunction

  function automatic logic [47:0] obs_bundle();
    return {inst_opcode, inst_op1, inst_op2, 6'd0, inst_len, inst_pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] model_pc, held_addr, len_tmp;
  logic        prev_stall, started;
  int          nbundles;

  initial begin
    rst = 1'b1; mem_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hEA;
    mem[16'h8001] = 8'h4C; mem[16'h8002] = 8'h34; mem[16'h8003] = 8'h12;
    mem[16'h8004] = 8'h4C; mem[16'h8005] = 8'hAA; mem[16'h8006] = 8'hBB;
    mem[16'hC000] = 8'hEA;

    // Reset state
    tick(); tick();
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_rd", mem_rd, 1'b0);
    chk("rst_len", inst_len, 2'd1);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_bundle", {inst_opcode, inst_op1, inst_op2, inst_pc}, 40'h0);
    rst = 1'b0; #1;
    chk("vec_lo_addr", {mem_rd, mem_addr}, {1'b1, 16'hFFFC});
    tick();
    chk("vec_hi_addr", {mem_rd, mem_addr}, {1'b1, 16'hFFFD});
    tick();
    chk("first_opc", {mem_rd, mem_addr}, {1'b1, 16'h8000});

    // 1-byte instruction, 3 cycles
    tick();
    chk("len1_op1_no_rd", mem_rd, 1'b0);
    tick();
    chk("len1_valid", inst_valid, 1'b1);
    chk("len1_bundle", obs_bundle(), {8'hEA, 8'h00, 8'h00, 6'd0, 2'd1, 16'h8000});
    tick();
    chk("len1_next", {inst_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h8001});

    // 3-byte instruction with two wait states per byte
    inst_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      held_addr = 16'h8001 + 16'(b);
      mem_ready = 1'b0;
      for (int w = 0; w < 2; w++) begin
        tick();
        chk("wait_hold", {mem_rd, mem_addr}, {1'b1, held_addr});
      end
      mem_ready = 1'b1;
      tick();
    end
    // Backpressure in HOLD
    for (int c = 0; c < 5; c++) begin
      chk("bp_state", {inst_valid, mem_rd}, 2'b10);
      chk("bp_bundle", obs_bundle(), {8'h4C, 8'h34, 8'h12, 6'd0, 2'd3, 16'h8001});
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("len3_next", {inst_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h8004});

    // Redirect during OP2 drops the operand and the bundle
    tick(); tick();
    chk("op2_addr", {mem_rd, mem_addr}, {1'b1, 16'h8006});
    redirect_valid = 1'b1; redirect_pc = 16'hC000;
    tick();
    redirect_valid = 1'b0;
    chk("redir_target", {inst_valid, mem_rd, mem_addr, pc_out}, {1'b0, 1'b1, 16'hC000, 16'hC000});
    tick(); tick();
    chk("redir_bundle", obs_bundle(), {8'hEA, 8'h00, 8'h00, 6'd0, 2'd1, 16'hC000});
    tick();

    // pc wrap on a 2-byte instruction at FFFF
    mem[16'hFFFF] = 8'h02; mem[16'h0000] = 8'h55; mem[16'h0001] = 8'h4C;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_op_addr", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    tick();
    chk("wrap_bundle", obs_bundle(), {8'h02, 8'h55, 8'h00, 6'd0, 2'd2, 16'hFFFF});
    chk("wrap_pc", pc_out, 16'h0001);
    tick();
    chk("wrap_next", mem_addr, 16'h0001);

    // Reset in OP1, then redirect in VEC_HI is ignored
    tick();
    chk("pre_rst_op1", {mem_rd, mem_addr}, {1'b1, 16'h0002});
    rst = 1'b1;
    tick();
    chk("mid_rst", {inst_valid, mem_rd, pc_out}, {1'b0, 1'b0, 16'h0000});
    rst = 1'b0; #1;
    chk("mid_rst_vec", mem_addr, 16'hFFFC);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h1234;
    tick();
    redirect_valid = 1'b0;
    chk("vec_redirect_ignored", {mem_rd, mem_addr}, {1'b1, 16'h8000});

    // Randomized run against the bundle-level model
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    rst = 1'b1; tick(); rst = 1'b0;
    model_pc = {mem[16'hFFFD], mem[16'hFFFC]};
    prev_stall = 1'b0; started = 1'b0; nbundles = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_stall) chk("rand_hold", {mem_rd, mem_addr}, {1'b1, held_addr});
      if (inst_valid) chk("rand_hold_no_rd", mem_rd, 1'b0);
      mem_ready      = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = started && ($urandom_range(0, 39) == 0);
      redirect_pc    = 16'($urandom);
      if (inst_valid && inst_ready) begin
        chk("rand_bundle", obs_bundle(), exp_bundle(model_pc));
        $display("bundle pc=%h op=%h %h %h len=%0d", inst_pc, inst_opcode, inst_op1, inst_op2, inst_len);
        len_tmp  = {14'd0, exp_bundle(model_pc)[17:16]};
        model_pc = model_pc + len_tmp;
        nbundles++;
        started = 1'b1;
      end
      if (redirect_valid) model_pc = redirect_pc;
      prev_stall = mem_rd && !mem_ready && !redirect_valid;
      held_addr  = mem_addr;
      tick();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 64'(nbundles >= 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end of the 6502 core.
- Generates byte reads to memory, starting from the reset vector and then at the program counter.
- Assembles each instruction's opcode plus 0–2 operand bytes and presents them to the decoder/execute stage with a valid/ready handshake.
- Uses the instruction length returned by the prime decoder.
- Accepts PC redirects from the branch/jump execute logic.

Parameters:
- RESET_VEC, 16'hFFFC, address of the low byte of the reset vector; the high byte is at RESET_VEC+1.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- mem_addr  output  16  read address
- mem_rd  output  1  read request; mem_addr is held stable while mem_rd=1 and mem_ready=0
- mem_rdata  input  8  read data, valid in the cycle mem_rd&mem_ready
- mem_ready  input  1  read completes this cycle when mem_rd=1
- len_in  input  2  instruction length from the decoder; combinational function of inst_opcode
- inst_opcode  output  8  captured opcode; feeds the decoder
- inst_op1  output  8  first operand byte (0 if len<2)
- inst_op2  output  8  second operand byte (0 if len<3)
- inst_len  output  2  latched length, 1..3
- inst_pc  output  16  address of the opcode byte
- inst_valid  output  1  instruction bundle valid
- inst_ready  input  1  consumer accepts the bundle
- redirect_valid  input  1  load new PC
- redirect_pc  input  16  redirect target
- pc_out  output  16  current fetch PC

Behaviour:
- Reset: while rst=1 at an edge:
  - state=VEC_LO, pc=0.
  - inst_valid=0, inst_opcode/op1/op2=0, inst_len=1, inst_pc=0.
  - mem_rd=0 during the reset cycle itself.
  - Reset mid-operation discards all partial state.
- Byte transfer: a transfer occurs on a clock edge with mem_rd=1 and mem_ready=1. mem_ready low stalls the FSM in its current state with address held.
- States:
  - VEC_LO: mem_addr=RESET_VEC, mem_rd=1. On transfer, pc[7:0]←rdata, go to VEC_HI.
  - VEC_HI: mem_addr=RESET_VEC+1, mem_rd=1. On transfer, pc[15:8]←rdata, go to OPC.
  - OPC: mem_addr=pc, mem_rd=1. On transfer:
    - inst_opcode←rdata, inst_pc←pc, pc←pc+1.
    - op1, op2 ← 0.
    - go to OP1.
  - OP1: eff_len = (len_in==0) ? 1 : len_in.
    - If eff_len==1: mem_rd=0; next cycle inst_len←1, go to HOLD.
    - Otherwise: mem_addr=pc, mem_rd=1. On transfer, op1←rdata, pc←pc+1, inst_len←eff_len; go to OP2 if eff_len==3, else HOLD.
  - OP2: mem_addr=pc, mem_rd=1. On transfer, op2←rdata, pc←pc+1, go to HOLD.
  - HOLD: inst_valid=1, mem_rd=0, bundle outputs stable. When inst_ready=1: inst_valid←0, go to OPC.
- inst_valid is registered; it is 1 only in HOLD.
- Minimum cycles per instruction with mem_ready tied high and inst_ready tied high:
  - len1: 3 (OPC, OP1, HOLD)
  - len2: 3
  - len3: 4
- len_in is sampled only in OP1.
- pc arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000. Wrap-around is legal; no fault is raised.
- Redirect:
  - Effective in states OPC, OP1, OP2 and HOLD. Ignored in VEC_LO/VEC_HI.
  - On an edge with redirect_valid=1: pc←redirect_pc, inst_valid←0, go to OPC.
  - Redirect has priority over a simultaneous byte transfer, whose data is dropped with no pc increment.
  - Redirect in HOLD with inst_ready=1 in the same cycle: the bundle counts as consumed, then the redirect applies.
  - mem_rd may drop in the cycle following a redirect before mem_ready. The memory side must tolerate an abandoned request.
- pc_out = pc register.

Test Plan:
- Reset vector: mem[FFFC]=00, mem[FFFD]=80, mem_ready=1 -> reads at FFFC, FFFD, then the first opcode read at 8000.
- 1-byte instruction: mem[8000]=EA, len_in=1 -> bundle opcode=EA, op1=op2=00, len=1, pc=8000; next mem_addr=8001; no read issued in OP1.
- 3-byte instruction with wait states: mem[8000..8002]=4C 34 12, len_in=3, mem_ready low 2 cycles per byte -> addr held; bundle 4C/34/12, len=3, pc=8000; next fetch at 8003.
- Backpressure: inst_ready=0 for 5 cycles -> inst_valid stays 1, bundle unchanged, mem_rd=0; release -> next fetch begins.
- Redirect: redirect_valid with redirect_pc=C000 during OP2 while mem_ready=1 -> op2 data dropped, no bundle issued, next opcode read at C000. redirect_valid during VEC_HI -> ignored.
- Wrap and reset: pc=FFFF with a 2-byte instruction -> operand read at 0000, next pc 0001. rst during OP1 -> inst_valid=0, restart at VEC_LO/FFFC.
